// File: rtl/mem_seq_ctrl_pkg.sv
// Shared types and helpers for the memory-stage load/store sequencer.
package mem_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    WRITE = 3'd1,
    READ  = 3'd2,
    DRAIN = 3'd3,
    DONE  = 3'd4
  } state_e;

  localparam logic OP_SCALAR = 1'b0;
  localparam logic OP_VECTOR = 1'b1;

  // Number of elements moved by one request.
  function automatic int unsigned elem_count(input logic op_type, input int unsigned i);
    return (op_type == OP_VECTOR) ? i : 32'd1;
  endfunction

endpackage

// File: rtl/mem_seq_ctrl_if.sv
// Request/response and RAM-port signals of the memory-stage sequencer.
interface mem_seq_ctrl_if #(
  parameter int I = 20,
  parameter int L = 8,
  parameter int A = 6
);

  // Pipeline side
  logic                start;
  logic                op_type;
  logic                write_enable;
  logic [A-1:0]        base_address;
  logic [I-1:0][L-1:0] vec_wdata;
  logic [L-1:0]        sca_wdata;
  logic [I-1:0][L-1:0] vector_output;
  logic [L-1:0]        scalar_output;
  logic                stall;
  logic                mem_finished;

  // RAM side
  logic [A-1:0]        mem_addr;
  logic [L-1:0]        mem_wdata;
  logic                mem_we;
  logic [L-1:0]        mem_rdata;

  modport master (
    input  start, op_type, write_enable, base_address, vec_wdata, sca_wdata, mem_rdata,
    output mem_addr, mem_wdata, mem_we, vector_output, scalar_output, stall, mem_finished
  );

  modport slave (
    output start, op_type, write_enable, base_address, vec_wdata, sca_wdata, mem_rdata,
    input  mem_addr, mem_wdata, mem_we, vector_output, scalar_output, stall, mem_finished
  );

endinterface

// File: rtl/mem_elem_counter.sv
// Element index counter: loads the last index at request accept, steps once per beat,
// and flags the final beat.
module mem_elem_counter #(
  parameter int  I  = 20,
  localparam int IW = (I > 1) ? $clog2(I) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr_i,
  input  logic          load_i,
  input  logic          en_i,
  input  logic [IW-1:0] last_idx_i,
  output logic [IW-1:0] idx_o,
  output logic          last_o
);

  logic [IW-1:0] idx_q, idx_d;
  logic [IW-1:0] last_idx_q, last_idx_d;

  // NOTE: every combinational output gets a default first, so no path leaves it
  // unassigned and no latch is inferred.
  always_comb begin
    idx_d      = idx_q;
    last_idx_d = last_idx_q;
    if (clr_i) begin
      idx_d = '0;
    end else if (load_i) begin
      idx_d      = '0;
      last_idx_d = last_idx_i;
    end else if (en_i) begin
      idx_d = idx_q + IW'(1);
    end
  end

  // NOTE: registers use non-blocking assignments so all flops update together
  // from values sampled before the edge.
  always_ff @(posedge clk) begin
    if (!rst) begin
      idx_q      <= '0;
      last_idx_q <= '0;
    end else begin
      idx_q      <= idx_d;
      last_idx_q <= last_idx_d;
    end
  end

  assign idx_o  = idx_q;
  assign last_o = (idx_q == last_idx_q);

endmodule

// File: rtl/mem_seq_ctrl.sv
// Memory-stage sequencer: serialises scalar/vector loads and stores onto a
// single-port byte-wide synchronous RAM, one element per cycle, stalling upstream.
module mem_seq_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int I = 20,
  parameter int L = 8,
  parameter int A = 6
) (
  input logic            clk,
  input logic            rst,
  mem_seq_ctrl_if.master bus
);

  localparam int IW = (I > 1) ? $clog2(I) : 1;

  state_e              state_q, state_d;
  logic                op_q;
  logic [A-1:0]        base_q;
  logic [I-1:0][L-1:0] vec_q;
  logic [L-1:0]        sca_q;
  logic [I-1:0][L-1:0] vec_out_q;
  logic [L-1:0]        sca_out_q;
  logic                rd_valid_q;
  logic [IW-1:0]       rd_idx_q;

  logic                accept;
  logic                beat_en;
  logic                last_beat;
  logic [IW-1:0]       idx;
  logic [IW-1:0]       last_idx;

  logic [A-1:0]        mem_addr;
  logic [L-1:0]        mem_wdata;
  logic                mem_we;

  assign accept   = (state_q == IDLE) && bus.start;
  assign last_idx = IW'(elem_count(bus.op_type, I) - 32'd1);

  mem_elem_counter #(.I(I)) u_cnt (
    .clk        (clk),
    .rst        (rst),
    .clr_i      (state_q == DONE),
    .load_i     (accept),
    .en_i       (beat_en),
    .last_idx_i (last_idx),
    .idx_o      (idx),
    .last_o     (last_beat)
  );

  always_comb begin
    state_d = state_q;
    beat_en = 1'b0;
    unique case (state_q)
      IDLE:    if (bus.start) state_d = bus.write_enable ? WRITE : READ;
      WRITE: begin
        beat_en = !last_beat;
        if (last_beat) state_d = DONE;
      end
      READ: begin
        beat_en = !last_beat;
        if (last_beat) state_d = DRAIN;
      end
      DRAIN:   state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Read data arrives one cycle after issue, so the issuing index is carried
  // alongside a valid flag; the DRAIN cycle collects the final element.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= IDLE;
      op_q       <= OP_SCALAR;
      base_q     <= '0;
      rd_valid_q <= 1'b0;
      rd_idx_q   <= '0;
      vec_out_q  <= '0;
      sca_out_q  <= '0;
    end else begin
      state_q    <= state_d;
      rd_valid_q <= (state_q == READ);
      rd_idx_q   <= idx;
      if (accept) begin
        op_q   <= bus.op_type;
        base_q <= bus.base_address;
      end
      if (rd_valid_q) begin
        if (op_q == OP_VECTOR) vec_out_q[rd_idx_q] <= bus.mem_rdata;
        else                   sca_out_q           <= bus.mem_rdata;
      end
    end
  end

  // NOTE: the store payload is left unreset; it is always written at accept
  // before any WRITE beat can read it.
  always_ff @(posedge clk) begin
    if (accept) begin
      vec_q <= bus.vec_wdata;
      sca_q <= bus.sca_wdata;
    end
  end

  // Address and data are forced to zero off-beat so the bus is quiet and X-free.
  always_comb begin
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (state_q == WRITE || state_q == READ) mem_addr = base_q + A'(idx);
    if (state_q == WRITE) begin
      mem_we    = 1'b1;
      mem_wdata = (op_q == OP_VECTOR) ? vec_q[idx] : sca_q;
    end
  end

  assign bus.mem_we        = mem_we;
  assign bus.mem_addr      = mem_addr;
  assign bus.mem_wdata     = mem_wdata;
  assign bus.mem_finished  = (state_q == DONE);
  assign bus.stall         = ((state_q != IDLE) && (state_q != DONE)) ||
                             ((state_q == IDLE) && bus.start);
  assign bus.vector_output = vec_out_q;
  assign bus.scalar_output = sca_out_q;

endmodule

// File: tb/tb_mem_seq_ctrl.sv
// Self-checking bench for mem_seq_ctrl: behavioural RAM, transaction-level
// reference model, table-driven vectors, hand-written corner sequences, random traffic.
module tb_mem_seq_ctrl;

  localparam int I     = 20;
  localparam int L     = 8;
  localparam int A     = 6;
  localparam int DEPTH = 1 << A;
  localparam int VW    = I * L;

  typedef logic [I-1:0][L-1:0] vec_t;
  typedef struct packed { logic [A-1:0] addr; logic [L-1:0] data; } wr_t;
  typedef struct {
    logic         op;
    logic         we;
    logic [A-1:0] base;
    logic [L-1:0] sca;
    int           exp_lat;
    int           exp_wr;
    logic [A-1:0] exp_last;
  } vec_rec_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mem_seq_ctrl_if #(.I(I), .L(L), .A(A)) bus ();
  mem_seq_ctrl #(.I(I), .L(L), .A(A)) dut (.clk(clk), .rst(rst), .bus(bus));

  // Synchronous single-port RAM, read data one cycle after the address.
  logic [L-1:0] ram [DEPTH];
  always @(posedge clk) begin
    if (bus.mem_we) ram[bus.mem_addr] <= bus.mem_wdata;
    bus.mem_rdata <= ram[bus.mem_addr];
  end

  wr_t wr_log[$];
  int  fin_cyc[$];
  int  cyc = 0;
  int  fin_cnt = 0;
  int  xfree_err = 0;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    if (bus.mem_we) wr_log.push_back('{addr: bus.mem_addr, data: bus.mem_wdata});
    else if (bus.mem_wdata != '0) xfree_err <= xfree_err + 1;
    if (bus.mem_finished) begin
      fin_cnt <= fin_cnt + 1;
      fin_cyc.push_back(cyc);
    end
  end

  // Reference model: RAM image and expected load results.
  logic [L-1:0] ref_mem [DEPTH];
  vec_t         exp_vec;
  logic [L-1:0] exp_sca;
  int           n_checks = 0;
  int           n_err = 0;

  task automatic check(input string name, input logic [VW-1:0] act, input logic [VW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [A-1:0] wrap_addr(input logic [A-1:0] b, input int k);
    return A'(int'(b) + k);
  endfunction

  // One request through the DUT, checked against the model. glitch_at > 0 pulses
  // start with another address in that cycle after accept.
  task automatic do_txn(input string name, input logic op, input logic we,
                        input logic [A-1:0] base, input logic [L-1:0] sca, input vec_t vec,
                        input int glitch_at, output int lat, output int nwr,
                        output logic [A-1:0] last_addr);
    int   n, exp_lat, wr0, fin0, stall_cnt;
    logic got;
    n        = op ? I : 1;
    exp_lat  = we ? n + 1 : n + 2;
    wr0      = wr_log.size();
    fin0     = fin_cnt;
    stall_cnt = 0;
    got      = 1'b0;
    bus.op_type      = op;
    bus.write_enable = we;
    bus.base_address = base;
    bus.sca_wdata    = sca;
    bus.vec_wdata    = vec;
    bus.start        = 1'b1;
    #1;
    if (bus.stall) stall_cnt++;
    @(posedge clk);
    lat = 0;
    while (!got && lat < 200) begin
      @(negedge clk);
      lat++;
      if (lat == 1) bus.start = 1'b0;
      if (glitch_at > 0 && lat == glitch_at) begin
        bus.start        = 1'b1;
        bus.base_address = base ^ 6'h21;
      end
      if (glitch_at > 0 && lat == glitch_at + 1) bus.start = 1'b0;
      #1;
      if (bus.stall) stall_cnt++;
      if (bus.mem_finished) got = 1'b1;
    end
    @(negedge clk);
    check({name, "_finished"}, got, 1'b1);
    check({name, "_latency"}, lat, exp_lat);
    check({name, "_stall_cycles"}, stall_cnt, exp_lat);
    check({name, "_fin_pulses"}, fin_cnt - fin0, 1);
    nwr = wr_log.size() - wr0;
    check({name, "_write_beats"}, nwr, we ? n : 0);
    last_addr = (nwr > 0) ? wr_log[wr_log.size() - 1].addr : '0;
    if (we) begin
      for (int k = 0; k < n; k++) ref_mem[wrap_addr(base, k)] = op ? vec[k] : sca;
      if (nwr == n) begin
        for (int k = 0; k < n; k++) begin
          check($sformatf("%s_wr%0d_addr", name, k), wr_log[wr0 + k].addr, wrap_addr(base, k));
          check($sformatf("%s_wr%0d_data", name, k), wr_log[wr0 + k].data, op ? vec[k] : sca);
        end
      end
    end else if (op) begin
      for (int k = 0; k < I; k++) exp_vec[k] = ref_mem[wrap_addr(base, k)];
    end else begin
      exp_sca = ref_mem[base];
    end
    check({name, "_vector_output"}, bus.vector_output, exp_vec);
    check({name, "_scalar_output"}, bus.scalar_output, exp_sca);
  endtask

  initial begin
    int           lat, nwr, fin0, wr0, fc0;
    logic [A-1:0] last;
    vec_t         v;
    vec_rec_t     tbl[8];
    int           bases[4];
    logic [L-1:0] mem_exp [DEPTH];

    rst = 1'b0;
    bus.start = 1'b0;
    bus.op_type = 1'b0;
    bus.write_enable = 1'b0;
    bus.base_address = '0;
    bus.vec_wdata = '0;
    bus.sca_wdata = '0;
    exp_vec = '0;
    exp_sca = '0;
    repeat (3) @(negedge clk);
    check("rst_mem_we", bus.mem_we, 1'b0);
    check("rst_mem_addr", bus.mem_addr, 0);
    check("rst_mem_wdata", bus.mem_wdata, 0);
    check("rst_mem_finished", bus.mem_finished, 1'b0);
    check("rst_vector_output", bus.vector_output, 0);
    check("rst_scalar_output", bus.scalar_output, 0);
    check("rst_stall", bus.stall, 1'b0);
    rst = 1'b1;
    @(negedge clk);

    // Scalar store A5 at 10
    do_txn("sca_store", 1'b0, 1'b1, 6'd10, 8'hA5, '0, 0, lat, nwr, last);
    check("sca_store_lat2", lat, 2);
    check("sca_store_addr10", last, 6'd10);

    // Fill RAM with k+1 through vector stores
    bases = '{0, 20, 40, 44};
    for (int b = 0; b < 4; b++) begin
      for (int k = 0; k < I; k++) v[k] = L'(bases[b] + k + 1);
      do_txn($sformatf("preload%0d", b), 1'b1, 1'b1, A'(bases[b]), '0, v, 0, lat, nwr, last);
    end

    // Vector load wrapping past address 63
    do_txn("wrap_load", 1'b1, 1'b0, 6'd50, '0, '0, 0, lat, nwr, last);
    check("wrap_load_lat22", lat, 22);
    check("wrap_vo0", bus.vector_output[0], 8'd51);
    check("wrap_vo13", bus.vector_output[13], 8'd64);
    check("wrap_vo14", bus.vector_output[14], 8'd1);
    check("wrap_vo19", bus.vector_output[19], 8'd6);

    // Vector store then scalar load
    for (int k = 0; k < I; k++) v[k] = L'(8'h10 + k);
    do_txn("vst_10k", 1'b1, 1'b1, 6'd0, '0, v, 0, lat, nwr, last);
    do_txn("sld_7", 1'b0, 1'b0, 6'd7, '0, '0, 0, lat, nwr, last);
    check("sld_7_value", bus.scalar_output, 8'h17);
    check("sld_7_vec_hold", bus.vector_output[0], 8'd51);

    // Start pulsed during a busy vector load
    do_txn("busy_load", 1'b1, 1'b0, 6'd0, '0, '0, 8, lat, nwr, last);
    check("busy_load_elem7", bus.vector_output[7], 8'h17);
    fin0 = fin_cnt;
    repeat (3) @(negedge clk);
    check("busy_no_extra_fin", fin_cnt - fin0, 0);

    // Back-to-back scalar loads with start held high
    fin0 = fin_cnt;
    fc0  = fin_cyc.size();
    wr0  = wr_log.size();
    bus.op_type = 1'b0;
    bus.write_enable = 1'b0;
    bus.base_address = 6'd3;
    bus.start = 1'b1;
    repeat (12) @(negedge clk);
    bus.start = 1'b0;
    repeat (3) @(negedge clk);
    exp_sca = ref_mem[3];
    check("b2b_pulses", fin_cnt - fin0, 3);
    check("b2b_writes", wr_log.size() - wr0, 0);
    if (fin_cyc.size() - fc0 == 3) begin
      check("b2b_spacing0", fin_cyc[fc0 + 1] - fin_cyc[fc0], 4);
      check("b2b_spacing1", fin_cyc[fc0 + 2] - fin_cyc[fc0 + 1], 4);
    end
    check("b2b_scalar", bus.scalar_output, exp_sca);

    // Table-driven vectors: op, we, base, sca, latency, write beats, last write address
    tbl[0] = '{1'b0, 1'b1, 6'd0,  8'h5A, 2,  1,  6'd0};
    tbl[1] = '{1'b1, 1'b1, 6'd62, 8'h00, 21, 20, 6'd17};
    tbl[2] = '{1'b0, 1'b0, 6'd63, 8'h00, 3,  0,  6'd0};
    tbl[3] = '{1'b1, 1'b0, 6'd62, 8'h00, 22, 0,  6'd0};
    tbl[4] = '{1'b0, 1'b1, 6'd63, 8'h3C, 2,  1,  6'd63};
    tbl[5] = '{1'b1, 1'b1, 6'd30, 8'h00, 21, 20, 6'd49};
    tbl[6] = '{1'b1, 1'b0, 6'd45, 8'h00, 22, 0,  6'd0};
    tbl[7] = '{1'b0, 1'b0, 6'd17, 8'h00, 3,  0,  6'd0};
    for (int r = 0; r < 8; r++) begin
      for (int k = 0; k < I; k++) v[k] = L'(r * 37 + k * 3 + 1);
      do_txn($sformatf("tbl%0d", r), tbl[r].op, tbl[r].we, tbl[r].base, tbl[r].sca, v, 0,
             lat, nwr, last);
      check($sformatf("tbl%0d_lat", r), lat, tbl[r].exp_lat);
      check($sformatf("tbl%0d_beats", r), nwr, tbl[r].exp_wr);
      if (tbl[r].exp_wr > 0) check($sformatf("tbl%0d_last_addr", r), last, tbl[r].exp_last);
    end

    // Random traffic
    for (int t = 0; t < 40; t++) begin
      for (int k = 0; k < I; k++) v[k] = L'($urandom);
      do_txn($sformatf("rnd%0d", t), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
             A'($urandom_range(0, DEPTH - 1)), L'($urandom), v, 0, lat, nwr, last);
    end

    // Reset after beat 5 of a vector store at base 0
    for (int k = 0; k < I; k++) v[k] = L'(8'hC0 + k);
    mem_exp = ref_mem;
    for (int k = 0; k <= 5; k++) mem_exp[k] = v[k];
    wr0  = wr_log.size();
    fin0 = fin_cnt;
    bus.op_type = 1'b1;
    bus.write_enable = 1'b1;
    bus.base_address = 6'd0;
    bus.vec_wdata = v;
    bus.start = 1'b1;
    @(posedge clk);
    repeat (6) @(negedge clk);
    bus.start = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    #1;
    check("abort_mem_we", bus.mem_we, 1'b0);
    check("abort_mem_addr", bus.mem_addr, 0);
    check("abort_mem_wdata", bus.mem_wdata, 0);
    check("abort_mem_finished", bus.mem_finished, 1'b0);
    check("abort_vector_output", bus.vector_output, 0);
    check("abort_scalar_output", bus.scalar_output, 0);
    check("abort_stall", bus.stall, 1'b0);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("abort_writes", wr_log.size() - wr0, 6);
    check("abort_no_fin", fin_cnt - fin0, 0);
    for (int k = 0; k < I; k++) check($sformatf("abort_ram%0d", k), ram[k], mem_exp[k]);
    ref_mem = mem_exp;
    exp_vec = '0;
    exp_sca = '0;

    do_txn("post_abort_load", 1'b1, 1'b0, 6'd0, '0, '0, 0, lat, nwr, last);

    for (int k = 0; k < DEPTH; k++) check($sformatf("final_ram%0d", k), ram[k], ref_mem[k]);
    check("wdata_zero_when_idle", xfree_err, 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
    $finish;
  end

endmodule
